// File: rtl/wr_sel_decoder_pipe.sv
// wr_sel_decoder_pipe: registered N-to-2^N one-hot write-select decoder with enable,
//   valid/ready on both sides, 1-entry skid buffer and a saturating decode counter.
// Latency: 1 cycle from accept to out_valid when the output register is empty or draining.
// Backpressure: out_ready=0 parks one extra item in the skid; in_ready drops while the skid is full.
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready    upstream handshake; in_ready = ~skid_full (registered)
//   in_addr, in_act      select index and enable (in_act=0 decodes to all-zero)
//   out_valid/out_ready  downstream handshake
//   out_onehot, out_addr decoded select and the index carried with it
//   dec_count            number of non-zero selects delivered, saturating
//
// Optional: `define WR_SEL_ZERO_MASK_EN to make index 0 ($zero) always decode to all-zero.

module wr_sel_decoder_pipe #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16,
    localparam int OUT_W = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              in_act,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_onehot,
    output logic [ADDR_W-1:0] out_addr,
    output logic [CNT_W-1:0]  dec_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [OUT_W-1:0] decode(input logic [ADDR_W-1:0] addr,
                                                input logic act);
        logic [OUT_W-1:0] d;
        d = '0;
        for (int i = 0; i < OUT_W; i++) begin
            d[i] = act && (addr == i[ADDR_W-1:0]);
        end
`ifdef WR_SEL_ZERO_MASK_EN
        // Register $zero is never written.
        if (addr == '0) begin
            d = '0;
        end
`endif
        return d;
    endfunction

    logic              skid_full;
    logic [OUT_W-1:0]  skid_onehot;
    logic [ADDR_W-1:0] skid_addr;

    logic             accept;
    logic             xfer;
    logic             out_load;
    logic [OUT_W-1:0] in_onehot;

    assign in_ready  = ~skid_full;
    assign accept    = in_valid & in_ready;
    assign xfer      = out_valid & out_ready;
    assign out_load  = ~out_valid | out_ready;
    assign in_onehot = decode(in_addr, in_act);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_onehot  <= '0;
            out_addr    <= '0;
            skid_full   <= 1'b0;
            skid_onehot <= '0;
            skid_addr   <= '0;
        end else if (out_load) begin
            // Skid holds the older item, so it wins; in_ready was 0, so nothing
            // is accepted in the cycle the skid empties.
            if (skid_full) begin
                out_valid  <= 1'b1;
                out_onehot <= skid_onehot;
                out_addr   <= skid_addr;
                skid_full  <= 1'b0;
            end else if (accept) begin
                out_valid  <= 1'b1;
                out_onehot <= in_onehot;
                out_addr   <= in_addr;
            end else begin
                out_valid  <= 1'b0;
            end
        end else if (accept) begin
            // Output stalled: park the new item. Skid is empty here because accept needs in_ready.
            skid_full   <= 1'b1;
            skid_onehot <= in_onehot;
            skid_addr   <= in_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_count <= '0;
        end else if (xfer && (out_onehot != '0) && (dec_count != CNT_MAX)) begin
            dec_count <= dec_count + 1'b1;
        end
    end

endmodule
